// File: rtl/cla_pkg.sv
// Shared constants and state type for the nibble-serial look-ahead adder.
// The state encoding is fixed so that the states read the same in every tool and waveform.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry look-ahead slice.
// c3 is the carry into bit 3, so the parent can derive signed overflow from it.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle adder: one look-ahead nibble per cycle, with the carry registered between nibbles.
// The result is held in DONE until the sink accepts it.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("cla_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [NIBBLE_W-1:0]  nib_a;
    logic [NIBBLE_W-1:0]  nib_b;
    logic [NIBBLE_W-1:0]  nib_s;
    logic                 c3;
    logic                 c4;
    int                   base;

    assign base     = int'(idx) * NIBBLE_W;
    assign nib_a    = op_a[base +: NIBBLE_W];
    assign nib_b    = op_b[base +: NIBBLE_W];
    assign in_ready = (state == IDLE) && !rst;

    cla4_slice u_slice (
        .a  (nib_a),
        .b  (nib_b),
        .c0 (carry),
        .s  (nib_s),
        .c3 (c3),
        .c4 (c4)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: NIBBLE_W] <= nib_s;
                    carry <= c4;
                    // idx parks on the last nibble rather than wrapping
                    if (idx == LAST) begin
                        cout      <= c4;
                        ovf       <= c3 ^ c4;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed and randomized bench for cla_serial_adder at WIDTH=16.
// Expected values come from plain integer addition in the bench itself.
module tb_cla_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int pass_cnt = 0;
    int total    = 0;
    int ops_done = 0;
    int handoffs = 0;

    cla_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1)
            handoffs <= handoffs + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {ovf, cout, sum} from plain arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] s;
        logic       v;
        s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        return {v, s};
    endfunction

    task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xc, input int pre, input int hold,
                      input bit dir, input logic [W+1:0] exp);
        int k;
        logic [W+1:0] got;
        repeat (pre) tick;
        a = xa;
        b = xb;
        cin = xc;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        if (dir) chk("in_ready_run", 32'(in_ready), 32'd0);
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            if (!dir) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end
            tick;
            k++;
            if (dir) chk("in_ready_busy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (out_valid !== 1'b1) begin
            chk("timeout", 32'(out_valid), 32'd1);
            return;
        end
        if (dir) chk("latency", 32'(k), 32'(NIB));
        got = {ovf, cout, sum};
        if (dir) begin
            chk("sum", 32'(sum), 32'(exp[W-1:0]));
            chk("cout", 32'(cout), 32'(exp[W]));
            chk("ovf", 32'(ovf), 32'(exp[W+1]));
        end else begin
            chk("rand_result", 32'(got), 32'(exp));
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            tick;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'({ovf, cout, sum}), 32'(got));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        ops_done++;
        chk("handoff_valid", 32'(out_valid), 32'd0);
        chk("back_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) tick;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        op(16'hFFFF, 16'h0001, 1'b0, 0, 0, 1'b1, {1'b0, 1'b1, 16'h0000});
        op(16'h7FFF, 16'h0001, 1'b0, 1, 0, 1'b1, {1'b1, 1'b0, 16'h8000});
        op(16'h8000, 16'h8000, 1'b0, 0, 0, 1'b1, {1'b1, 1'b1, 16'h0000});
        op(16'h1234, 16'h4321, 1'b1, 0, 0, 1'b1, {1'b0, 1'b0, 16'h5556});
        op(16'hA5A5, 16'h0F0F, 1'b1, 0, 5, 1'b1, {1'b0, 1'b0, 16'hB4B5});

        // abort an operation with idx at 2
        a = 16'h1111;
        b = 16'h2222;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        op(16'h0F0F, 16'hF0F1, 1'b0, 0, 0, 1'b1, {1'b0, 1'b1, 16'h0000});

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            op(ra, rb, rc, $urandom_range(0, 2), $urandom_range(0, 2),
               1'b0, model(ra, rb, rc));
        end

        tick;
        chk("handoff_count", 32'(handoffs), 32'(ops_done));
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
